// File: rtl/muntjac_pkg.sv
// Shared front-end types for the fetch path.
//   exc_cause_t     : fetch fault cause codes
//   fetched_instr_t : one aligned instruction handed to the instruction buffer
package muntjac_pkg;

  typedef enum logic [3:0] {
    EXC_CAUSE_INSN_ADDR_MISA     = 4'd0,
    EXC_CAUSE_INSTR_ACCESS_FAULT = 4'd1,
    EXC_CAUSE_ILLEGAL_INSN       = 4'd2,
    EXC_CAUSE_BREAKPOINT         = 4'd3,
    EXC_CAUSE_INSTR_PAGE_FAULT   = 4'd12
  } exc_cause_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr_word;
    logic [3:0]  if_reason;
    logic        ex_valid;
    exc_cause_t  exception;
  } fetched_instr_t;

endpackage

// File: rtl/muntjac_instr_align.sv
// Instruction aligner: splits 4-byte-aligned fetch words into up to two
// RISC-V instructions (16- or 32-bit), carrying the lower half of a 32-bit
// instruction that straddles two fetch words in a one-entry pending register.
//
// Ports
//   clk_i, rst_ni      : clock, async active-low reset
//   flush_i            : drop the pending half-word at the next edge
//   req_valid_i/ready_o: fetch word handshake
//   req_pc_i           : PC of first useful half-word
//   req_word_i         : fetched word
//   req_if_reason_i    : nonzero marks a redirect target (pending ignored)
//   req_ex_valid_i,
//   req_exception_i    : fetch fault and its cause
//   out_ready_i        : downstream accepts both slots
//   out_valid_o        : slot valids (slot 0 oldest)
//   out_instr_o        : aligned instructions
module muntjac_instr_align
  import muntjac_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [63:0]              req_pc_i,
  input  logic [31:0]              req_word_i,
  input  logic [3:0]               req_if_reason_i,
  input  logic                     req_ex_valid_i,
  input  exc_cause_t               req_exception_i,
  input  logic                     out_ready_i,
  output logic [1:0]               out_valid_o,
  output fetched_instr_t [1:0]     out_instr_o
);

  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

  logic        pend_valid_q, pend_valid_d;
  logic [15:0] pend_half_q;
  logic [63:0] pend_pc_q;

  logic [15:0] lo_half, hi_half;
  logic [63:0] hi_pc;
  logic        use_pend;
  logic        upper_en;
  logic        slot_sel;
  logic        handshake;

  assign lo_half  = req_word_i[15:0];
  assign hi_half  = req_word_i[31:16];
  assign hi_pc    = {req_pc_i[63:2], 2'b10};
  // A redirect target never continues a previous instruction.
  assign use_pend = pend_valid_q && (req_if_reason_i == 4'd0);

  always_comb begin
    out_valid_o  = 2'b00;
    out_instr_o  = '0;
    pend_valid_d = 1'b0;
    upper_en     = 1'b0;
    slot_sel     = 1'b0;

    if (req_valid_i) begin
      if (req_ex_valid_i) begin
        // Faulting word: one slot carrying the fault, nothing retained.
        out_valid_o                  = 2'b01;
        out_instr_o[0].pc            = use_pend ? pend_pc_q : req_pc_i;
        out_instr_o[0].instr_word    = req_word_i;
        out_instr_o[0].ex_valid      = 1'b1;
        out_instr_o[0].exception     = req_exception_i;
      end else if (use_pend) begin
        out_valid_o[0]               = 1'b1;
        out_instr_o[0].pc            = pend_pc_q;
        out_instr_o[0].instr_word    = {lo_half, pend_half_q};
        upper_en                     = 1'b1;
        slot_sel                     = 1'b1;
      end else if (!req_pc_i[1]) begin
        out_valid_o[0]               = 1'b1;
        out_instr_o[0].pc            = req_pc_i;
        if (is_compressed(lo_half)) begin
          out_instr_o[0].instr_word  = {16'h0000, lo_half};
          upper_en                   = 1'b1;
          slot_sel                   = 1'b1;
        end else begin
          out_instr_o[0].instr_word  = req_word_i;
        end
      end else begin
        upper_en                     = 1'b1;
      end

      // Upper half lands in the next free slot, or waits for its partner.
      if (upper_en) begin
        if (is_compressed(hi_half)) begin
          out_valid_o[slot_sel]            = 1'b1;
          out_instr_o[slot_sel].pc         = hi_pc;
          out_instr_o[slot_sel].instr_word = {16'h0000, hi_half};
        end else begin
          pend_valid_d = 1'b1;
        end
      end

      if (out_valid_o[0]) out_instr_o[0].if_reason = req_if_reason_i;
    end
  end

  assign req_ready_o = out_ready_i || !out_valid_o[0];
  assign handshake   = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        pend_valid_q <= 1'b0;
    else if (flush_i)   pend_valid_q <= 1'b0;
    else if (handshake) pend_valid_q <= pend_valid_d;
  end

  // Payload is meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk_i) begin
    if (handshake && pend_valid_d) begin
      pend_half_q <= hi_half;
      pend_pc_q   <= hi_pc;
    end
  end

endmodule

// File: tb/tb_muntjac_instr_align.sv
module tb_muntjac_instr_align;
  import muntjac_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 flush_i = 1'b0;
  logic                 req_valid_i = 1'b0;
  logic                 req_ready_o;
  logic [63:0]          req_pc_i = '0;
  logic [31:0]          req_word_i = '0;
  logic [3:0]           req_if_reason_i = '0;
  logic                 req_ex_valid_i = 1'b0;
  exc_cause_t           req_exception_i = EXC_CAUSE_INSN_ADDR_MISA;
  logic                 out_ready_i = 1'b0;
  logic [1:0]           out_valid_o;
  fetched_instr_t [1:0] out_instr_o;

  int checks = 0;
  int failures = 0;

  // Reference pending state: a half-word waiting for its upper partner.
  logic        m_pv = 1'b0;
  logic [15:0] m_ph = '0;
  logic [63:0] m_ppc = '0;

  always #5 clk_i = ~clk_i;

  muntjac_instr_align dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_pc_i       (req_pc_i),
    .req_word_i     (req_word_i),
    .req_if_reason_i(req_if_reason_i),
    .req_ex_valid_i (req_ex_valid_i),
    .req_exception_i(req_exception_i),
    .out_ready_i    (out_ready_i),
    .out_valid_o    (out_valid_o),
    .out_instr_o    (out_instr_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Treat the request as a stream of half-words (pending first), then parse
  // instructions off the front of the stream until it runs dry.
  task automatic model(output logic [1:0] ev, output fetched_instr_t e0, output fetched_instr_t e1,
                       output logic nv, output logic [15:0] nh, output logic [63:0] npc);
    logic [15:0]    hq[$];
    logic [63:0]    pq[$];
    fetched_instr_t outs[$];
    fetched_instr_t t;
    logic           usep;
    int             k0;
    ev = '0; e0 = '0; e1 = '0; nv = m_pv; nh = m_ph; npc = m_ppc;
    if (!req_valid_i) return;
    usep = m_pv && (req_if_reason_i == 4'd0);
    nv = 1'b0;
    if (req_ex_valid_i) begin
      t = '0;
      t.pc = usep ? m_ppc : req_pc_i;
      t.ex_valid = 1'b1;
      t.exception = req_exception_i;
      outs.push_back(t);
    end else begin
      if (usep) begin
        hq.push_back(m_ph);
        pq.push_back(m_ppc);
      end
      k0 = (usep || !req_pc_i[1]) ? 0 : 1;
      for (int k = k0; k < 2; k++) begin
        hq.push_back(req_word_i[16*k +: 16]);
        pq.push_back({req_pc_i[63:2], 2'b00} + 64'(2*k));
      end
      while (hq.size() > 0) begin
        t = '0;
        t.pc = pq[0];
        if (hq[0][1:0] != 2'b11) begin
          t.instr_word = {16'h0000, hq[0]};
          outs.push_back(t);
          void'(hq.pop_front()); void'(pq.pop_front());
        end else if (hq.size() >= 2) begin
          t.instr_word = {hq[1], hq[0]};
          outs.push_back(t);
          void'(hq.pop_front()); void'(pq.pop_front());
          void'(hq.pop_front()); void'(pq.pop_front());
        end else begin
          nv = 1'b1; nh = hq[0]; npc = pq[0];
          void'(hq.pop_front()); void'(pq.pop_front());
        end
      end
    end
    if (outs.size() > 0) begin
      outs[0].if_reason = req_if_reason_i;
      e0 = outs[0];
      ev[0] = 1'b1;
    end
    if (outs.size() > 1) begin
      e1 = outs[1];
      ev[1] = 1'b1;
    end
  endtask

  task automatic step(input string tag);
    logic [1:0]     ev;
    fetched_instr_t ex[2];
    logic           nv;
    logic [15:0]    nh;
    logic [63:0]    npc;
    logic           hs;
    @(negedge clk_i);
    model(ev, ex[0], ex[1], nv, nh, npc);
    chk({tag, ".valid"}, 64'(out_valid_o), 64'(ev));
    chk({tag, ".ready"}, 64'(req_ready_o), 64'(out_ready_i || !ev[0]));
    for (int s = 0; s < 2; s++) begin
      if (ev[s]) begin
        chk($sformatf("%s.s%0d.pc", tag, s), out_instr_o[s].pc, ex[s].pc);
        if (!ex[s].ex_valid)
          chk($sformatf("%s.s%0d.iw", tag, s), 64'(out_instr_o[s].instr_word), 64'(ex[s].instr_word));
        chk($sformatf("%s.s%0d.rsn", tag, s), 64'(out_instr_o[s].if_reason), 64'(ex[s].if_reason));
        chk($sformatf("%s.s%0d.exv", tag, s), 64'(out_instr_o[s].ex_valid), 64'(ex[s].ex_valid));
        if (ex[s].ex_valid)
          chk($sformatf("%s.s%0d.exc", tag, s), 64'(out_instr_o[s].exception), 64'(ex[s].exception));
      end
    end
    hs = req_valid_i && (out_ready_i || !ev[0]);
    @(posedge clk_i);
    if (flush_i) m_pv = 1'b0;
    else if (hs) begin
      m_pv = nv; m_ph = nh; m_ppc = npc;
    end
    #1;
  endtask

  task automatic drive(input string tag, input logic v, input logic [63:0] pc, input logic [31:0] w,
                       input logic [3:0] r, input logic ex, input exc_cause_t c,
                       input logic rdy, input logic fl);
    req_valid_i = v; req_pc_i = pc; req_word_i = w; req_if_reason_i = r;
    req_ex_valid_i = ex; req_exception_i = c; out_ready_i = rdy; flush_i = fl;
    step(tag);
  endtask

  initial begin
    #12 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    drive("rst_idle", 0, 64'h0, 32'h0, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);

    drive("two_c",    1, 64'h1000, 32'h0001_0001, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);
    drive("two_c_nx", 1, 64'h1004, 32'h0001_0093, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);

    drive("str_a", 1, 64'h1000, 32'h0013_0001, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);
    drive("str_b", 1, 64'h1004, 32'hABCD_0093, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);

    drive("rd_a",   1, 64'h1000, 32'h0013_0001, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);
    drive("redir",  1, 64'h2002, 32'h0001_0093, 4'd1, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);
    drive("rd_chk", 1, 64'h2004, 32'h0001_0093, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);

    drive("ex_a",   1, 64'h1000, 32'h0013_0001, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);
    drive("ex",     1, 64'h1004, 32'h0001_0093, 4'd0, 1, EXC_CAUSE_INSTR_ACCESS_FAULT, 1, 0);
    drive("ex_chk", 1, 64'h1008, 32'h0001_0093, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);

    drive("st_a",   1, 64'h3000, 32'h0013_0001, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);
    drive("stall1", 1, 64'h3004, 32'h0001_0093, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 0, 0);
    drive("stall2", 1, 64'h3004, 32'h0001_0093, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 0, 1);
    drive("stall3", 1, 64'h3004, 32'h0001_0093, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 0, 0);
    drive("st_post",1, 64'h3004, 32'h0001_0093, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);

    drive("rs_a", 1, 64'h1000, 32'h0013_0001, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);
    req_valid_i = 1'b0;
    rst_ni = 1'b0; m_pv = 1'b0;
    #2 rst_ni = 1'b1;
    drive("rs_idle", 0, 64'h1004, 32'h0001_0093, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);
    drive("rs_post", 1, 64'h1004, 32'h0001_0093, 4'd0, 0, EXC_CAUSE_INSN_ADDR_MISA, 1, 0);

    for (int i = 0; i < 600; i++) begin
      logic [63:0] pc;
      logic [31:0] w;
      logic [3:0]  r;
      exc_cause_t  c;
      r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      pc = {$urandom, $urandom};
      pc[1:0] = 2'b00;
      pc[1] = 1'($urandom_range(0, 1));
      if (m_pv && r == 4'd0) pc[1] = 1'b0;
      w = $urandom;
      case ($urandom_range(0, 2))
        0:       c = EXC_CAUSE_INSTR_ACCESS_FAULT;
        1:       c = EXC_CAUSE_INSTR_PAGE_FAULT;
        default: c = EXC_CAUSE_ILLEGAL_INSN;
      endcase
      drive($sformatf("rnd%0d", i), ($urandom_range(0, 9) != 0), pc, w, r,
            ($urandom_range(0, 9) == 0), c, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muntjac_instr_align.md
MUNTJAC_INSTR_ALIGN -- requirements
Module: muntjac_instr_align

Interface
REQ-001 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-002 SHALL have port rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port flush_i  in  1  discard the pending half-word at the next edge.
REQ-004 SHALL have port req_valid_i  in  1  fetch word valid.
REQ-005 SHALL have port req_ready_o  out  1  fetch word consumed this cycle.
REQ-006 SHALL have port req_pc_i  in  64  PC of first useful half-word; bit 0 always 0.
REQ-007 SHALL have port req_word_i  in  32  word from the 4-byte-aligned fetch address.
REQ-008 SHALL have port req_if_reason_i  in  4  fetch reason; nonzero means a redirect target.
REQ-009 SHALL have port req_ex_valid_i  in  1  fetch fault for this word.
REQ-010 SHALL have port req_exception_i  in  exc_cause_t  fault cause.
REQ-011 SHALL have port out_ready_i  in  1  downstream instruction buffer accepts both slots.
REQ-012 SHALL have port out_valid_o  out  2  slot valids; out_valid_o[1] implies out_valid_o[0].
REQ-013 SHALL have port out_instr_o  out  2 x fetched_instr_t  aligned instructions, slot 0 oldest.

Function
REQ-014 SHALL classify a half-word as compressed iff bits[1:0] != 2'b11.
REQ-015 SHALL hold one pending register: valid bit, 16-bit lower half, 64-bit PC of a 32-bit instruction straddling words.
REQ-016 SHALL ignore pending state for a word whose req_if_reason_i != 0; the word is treated as if pending were invalid.
REQ-017 SHALL, if pending is valid, emit slot 0 = {req_word_i[15:0], pending half} at the pending PC, then process the upper half.
REQ-018 SHALL, if pending is invalid and req_pc_i[1]=0, emit slot 0 = lower half (compressed) or the full word (not compressed, 32-bit instruction, done).
REQ-019 SHALL, if pending is invalid and req_pc_i[1]=1, skip the lower half and process the upper half only.
REQ-020 SHALL process the upper half as follows: if compressed, emit it in the next free slot at PC {req_pc_i[63:2],2'b10}; if not compressed, store it as pending and emit nothing for it.
REQ-021 SHALL zero-extend compressed halves into instr_word[31:16].
REQ-022 SHALL, when req_ex_valid_i=1, emit only slot 0 with ex_valid=1 and exception=req_exception_i, at the pending PC if pending is used, else at req_pc_i; pending is cleared.
REQ-023 SHALL copy req_if_reason_i into slot 0 only; slot 1 if_reason SHALL be 0; slot ex_valid SHALL otherwise be 0.
REQ-024 SHALL drive outputs combinationally from the request and pending state, with zero latency; out_valid_o = 0 when req_valid_i = 0.
REQ-025 SHALL drive req_ready_o = out_ready_i || !out_valid_o[0].
REQ-026 SHALL update pending only on the req_valid_i && req_ready_o handshake.
REQ-027 SHALL give flush_i priority over a same-cycle handshake: pending becomes invalid regardless.
REQ-028 SHALL keep out_valid_o and out_instr_o stable while req_valid_i=1 and out_ready_i=0, with no state change.

Reset
REQ-029 SHALL clear the pending valid bit on reset; the pending half and PC are don't-care.
REQ-030 SHALL, after reset, produce out_valid_o=2'b00 until req_valid_i=1; reset mid-stream SHALL discard any pending half.

Structure
REQ-031 SHALL take fetched_instr_t (pc, instr_word, if_reason, ex_valid, exception) and exc_cause_t from muntjac_pkg; no new package types.
REQ-032 SHALL be a single flat module; an optional helper function SHALL be used for compressed detection, with no sub-module.

Verification
REQ-033 SHALL test: word 0x00010001, pc 0x1000 -> two compressed outputs at 0x1000 and 0x1002, pending stays invalid.
REQ-034 SHALL test: 0x00130001 at 0x1000, then 0x????0093 at 0x1004 -> first word emits 0x1000 only; second emits 32-bit 0x00930013 at 0x1002.
REQ-035 SHALL test: pending valid, next word has if_reason=1, pc 0x2002, compressed upper half -> single output at 0x2002 with if_reason=1; old pending dropped.
REQ-036 SHALL test: pending valid, next word ex_valid=1 -> one output, ex_valid=1, pc = pending PC, pending cleared.
REQ-037 SHALL test: out_ready_i=0 for 3 cycles with two valid slots -> outputs stable, req_ready_o=0; flush_i asserted mid-stall -> pending invalid next cycle.
